bram_initiator: RTL and testbench

- Initiator (master) for the on-chip memory slave port.
- Converts a CPU-side valid/ready command stream and a valid/ready response stream into onchip_memory_* pin activity.
- Tracks fixed read latency and buffers read data in a credit-protected response FIFO, so upstream may stall responses without losing data.
- Sits between the soft-core data/instruction bus and the bram block.

---
 rtl/bram_pkg.sv | 35 +++
 rtl/bram_rsp_fifo.sv | 80 ++++++++
 rtl/bram_initiator.sv | 185 ++++++++++++++++++
 tb/tb_bram_initiator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared defaults and width helpers for the on-chip memory initiator.
// The module-level parameters of bram_initiator default to these values;
// the helper functions derive dependent widths from whatever parameters a
// particular instance actually uses.
package bram_pkg;

    // Word-address width, matching onchip_memory_address.
    localparam int ADDR_W_DEF       = 10;

    // Data width; byte lanes are DATA_W/8.
    localparam int DATA_W_DEF       = 32;

    // Cycles from the memory sampling an address to readdata valid (1..3).
    localparam int READ_LATENCY_DEF = 1;

    // Response FIFO entries, which is also the number of read credits.
    localparam int RSP_DEPTH_DEF    = 4;

    // Byte-enable width for the default data width.
    localparam int BE_W             = DATA_W_DEF / 8;

    // Occupancy counter width for the default depth; it must represent 0..RSP_DEPTH.
    localparam int OCC_W            = $clog2(RSP_DEPTH_DEF + 1);

    // Byte-enable width for an arbitrary data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the CPU side accepts it.
// A push and a pop in the same cycle are both honoured, including when full.
// The head entry is presented combinationally, so o_pop_data stays stable
// for as long as the head is not popped.
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = RSP_DEPTH_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_empty,
    output logic              o_full
);

    // DEPTH is a power of two, so the pointers wrap on their own.
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_do_push;
    logic              w_do_pop;

    // A pop frees the slot this cycle, so a push into a full FIFO is legal
    // when it coincides with a pop.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == DEPTH_C);
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage array write port.
    // NOTE: the data array is deliberately not reset; only the pointers and
    // count need a known value, and resetting storage wastes reset routing.
    always_ff @(posedge clk_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Write and read pointers advance on accepted push / pop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Entry count; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_initiator.sv
// Initiator for the on-chip memory slave port.
// Accepts CPU read/write commands on a valid/ready stream, drives the
// onchip_memory_* pins one cycle after acceptance, tracks the fixed read
// latency with a valid shift register and parks returning read data in a
// response FIFO. Reads are only accepted while a FIFO slot is guaranteed
// (credit counter), so the CPU may stall responses indefinitely without loss.
module bram_initiator
    import bram_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF,  // legal range 1..3
    parameter int RSP_DEPTH    = RSP_DEPTH_DEF      // power of 2, >= 2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,

    // CPU command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_address,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic [DATA_W/8-1:0]   cmd_mask,

    // CPU response stream (reads only)
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,

    // On-chip memory slave pins
    output logic [ADDR_W-1:0]     onchip_memory_address,
    output logic                  onchip_memory_chipselect,
    output logic                  onchip_memory_clken,
    output logic                  onchip_memory_write,
    output logic [DATA_W-1:0]     onchip_memory_writedata,
    output logic [DATA_W/8-1:0]   onchip_memory_byteenable,
    input  logic [DATA_W-1:0]     onchip_memory_readdata
);

    localparam int                  L_BE_W   = be_width(DATA_W);
    localparam int                  L_OCC_W  = occ_width(RSP_DEPTH);
    localparam logic [L_OCC_W-1:0]  DEPTH_C  = L_OCC_W'(RSP_DEPTH);

    // Out-of-reset flag: holds clken and cmd_ready low while in reset.
    logic                     r_run;

    // Issue-stage registers that directly drive the memory pins.
    logic                     r_cs;
    logic                     r_we;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_wdata;
    logic [L_BE_W-1:0]        r_be;

    // One bit per cycle of read latency; the top bit marks readdata valid.
    logic [READ_LATENCY-1:0]  r_pipe;

    // Reads accepted and not yet popped (outstanding credits in use).
    logic [L_OCC_W-1:0]       r_occ;
    logic [L_OCC_W-1:0]       w_occ_next;

    logic                     w_accept;
    logic                     w_rd_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic [DATA_W-1:0]        w_fifo_data;

    // Ready depends only on registered state, so there is no combinational
    // path from any CPU input back to cmd_ready. Writes are gated by the
    // same condition to keep the command stream strictly ordered.
    assign cmd_ready   = r_run && (r_occ < DEPTH_C);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_rd_accept = w_accept && !cmd_write;

    assign rsp_valid   = !w_fifo_empty;
    assign rsp_data    = w_fifo_data;
    assign w_pop       = rsp_valid && rsp_ready;

    // Read data is captured READ_LATENCY cycles after the memory sampled the address.
    assign w_push      = r_pipe[READ_LATENCY-1];

    assign onchip_memory_address    = r_addr;
    assign onchip_memory_chipselect = r_cs;
    assign onchip_memory_clken      = r_run;
    assign onchip_memory_write      = r_we;
    assign onchip_memory_writedata  = r_wdata;
    assign onchip_memory_byteenable = r_be;

    // Leave reset on the first clock edge after reset_reset_n rises.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Issue stage: register an accepted command onto the memory pins for one cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_cs   <= 1'b1;
            r_we   <= cmd_write;
            r_addr <= cmd_address;
            if (cmd_write) begin
                r_wdata <= cmd_data;
                r_be    <= cmd_mask;
            end else begin
                // Reads fetch the whole word; writedata keeps its last value.
                r_be    <= '1;
            end
        end else begin
            // Idle cycle: deselect, but leave address/data/enables parked.
            r_cs <= 1'b0;
            r_we <= 1'b0;
        end
    end

    // Latency pipe: tag a read when the memory samples it, shift toward capture.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= r_cs && !r_we;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Next credit count: +1 on read accept, -1 on response pop.
    // NOTE: the default assignment first keeps this block free of latches
    // on paths that would otherwise leave w_occ_next unassigned.
    always_comb begin
        w_occ_next = r_occ;
        case ({w_rd_accept, w_pop})
            2'b10:   w_occ_next = r_occ + L_OCC_W'(1);
            2'b01:   w_occ_next = r_occ - L_OCC_W'(1);
            default: w_occ_next = r_occ;
        endcase
    end

    // Credit counter register; reset also forgets any reads still in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    bram_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .i_push        (w_push),
        .i_push_data   (onchip_memory_readdata),
        .i_pop         (w_pop),
        .o_pop_data    (w_fifo_data),
        .o_empty       (w_fifo_empty),
        .o_full        (w_fifo_full)
    );

    // Every returning read already holds a credit, so the FIFO can never be full on a push.
    a_no_fifo_overflow: assert property (
        @(posedge clk_clk) disable iff (!reset_reset_n) !(w_push && w_fifo_full)
    );

    // The credit counter never exceeds the FIFO depth.
    a_occ_in_range: assert property (
        @(posedge clk_clk) disable iff (!reset_reset_n) r_occ <= DEPTH_C
    );

endmodule

// File: tb/tb_bram_initiator.sv
// Self-checking bench for bram_initiator.
// A behavioural memory slave answers the pins. A scoreboard keeps a shadow
// copy of memory contents, the in-order list of expected read responses with
// the earliest cycle each may appear, the outstanding-read count, and the
// pin values the last accepted command should have produced.
module tb_bram_initiator;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_address;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [9:0]  onchip_memory_address;
    logic        onchip_memory_chipselect;
    logic        onchip_memory_clken;
    logic        onchip_memory_write;
    logic [31:0] onchip_memory_writedata;
    logic [3:0]  onchip_memory_byteenable;
    logic [31:0] onchip_memory_readdata;

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboard / reference state
    logic [31:0] shadow [0:1023];
    rsp_t        exp_q [$];
    int          m_occ;
    logic        m_cs;
    logic        m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    int          cyc = 0;
    int          last_rd_cyc = 0;
    int          n_pops = 0;
    int          pop_first = -1;
    int          pop_last = -1;
    logic [31:0] last_pop_data = '0;

    // Behavioural memory slave
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [LAT];

    always #5 clk_clk = ~clk_clk;

    bram_initiator #(
        .ADDR_W       (10),
        .DATA_W       (32),
        .READ_LATENCY (LAT),
        .RSP_DEPTH    (DEPTH)
    ) dut (
        .clk_clk                  (clk_clk),
        .reset_reset_n            (reset_reset_n),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_write                (cmd_write),
        .cmd_address              (cmd_address),
        .cmd_data                 (cmd_data),
        .cmd_mask                 (cmd_mask),
        .rsp_valid                (rsp_valid),
        .rsp_ready                (rsp_ready),
        .rsp_data                 (rsp_data),
        .onchip_memory_address    (onchip_memory_address),
        .onchip_memory_chipselect (onchip_memory_chipselect),
        .onchip_memory_clken      (onchip_memory_clken),
        .onchip_memory_write      (onchip_memory_write),
        .onchip_memory_writedata  (onchip_memory_writedata),
        .onchip_memory_byteenable (onchip_memory_byteenable),
        .onchip_memory_readdata   (onchip_memory_readdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Memory slave: writes merge by byte lane, reads return after LAT edges.
    always @(posedge clk_clk) begin
        if (onchip_memory_clken && onchip_memory_chipselect) begin
            if (onchip_memory_write) begin
                mem[onchip_memory_address] <= merge(mem[onchip_memory_address],
                                                    onchip_memory_writedata,
                                                    onchip_memory_byteenable);
            end else begin
                rd_pipe[0] <= mem[onchip_memory_address];
            end
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign onchip_memory_readdata = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_occ = 0;
        m_cs  = 1'b0;
        m_we  = 1'b0;
        m_addr = '0;
        m_wd  = '0;
        m_be  = '0;
    endtask

    // One clock cycle, entered and left at a negedge with inputs already driven.
    task automatic cycle();
        logic exp_valid;
        check("pin_cs",    32'(onchip_memory_chipselect), 32'(m_cs));
        check("pin_write", 32'(onchip_memory_write),      32'(m_we));
        check("pin_addr",  32'(onchip_memory_address),    32'(m_addr));
        check("pin_wdata", onchip_memory_writedata,       m_wd);
        check("pin_be",    32'(onchip_memory_byteenable), 32'(m_be));
        check("pin_clken", 32'(onchip_memory_clken),      32'(1'b1));
        check("cmd_ready", 32'(cmd_ready),                32'(m_occ < DEPTH));
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
            check("rsp_data", rsp_data, exp_q[0].data);
            last_pop_data = rsp_data;
            void'(exp_q.pop_front());
            m_occ--;
            n_pops++;
            if (pop_first < 0) pop_first = cyc;
            pop_last = cyc;
        end
        if (cmd_valid && cmd_ready) begin
            m_cs   = 1'b1;
            m_we   = cmd_write;
            m_addr = cmd_address;
            if (cmd_write) begin
                m_wd = cmd_data;
                m_be = cmd_mask;
                shadow[cmd_address] = merge(shadow[cmd_address], cmd_data, cmd_mask);
            end else begin
                m_be = 4'hF;
                exp_q.push_back('{data: shadow[cmd_address], due: cyc + LAT + 2});
                m_occ++;
                last_rd_cyc = cyc;
            end
        end else begin
            m_cs = 1'b0;
            m_we = 1'b0;
        end
        cyc++;
        @(posedge clk_clk);
        @(negedge clk_clk);
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int waited);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_data    = d;
        cmd_mask    = m;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            cycle();
            waited++;
        end
        if (!cmd_ready) check("issue_timeout", 32'(cmd_ready), 32'(1'b1));
        else cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
        repeat (3) cycle();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int w;
        int stalls;
        int p0;

        reset_reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_address = '0;
        cmd_data = '0;
        cmd_mask = '0;
        rsp_ready = 1'b0;
        model_reset();

        // Reset values
        #1;
        check("rst_cs",    32'(onchip_memory_chipselect), 32'(0));
        check("rst_write", 32'(onchip_memory_write),      32'(0));
        check("rst_clken", 32'(onchip_memory_clken),      32'(0));
        check("rst_addr",  32'(onchip_memory_address),    32'(0));
        check("rst_wdata", onchip_memory_writedata,       32'(0));
        check("rst_be",    32'(onchip_memory_byteenable), 32'(0));
        check("rst_rspv",  32'(rsp_valid),                32'(0));
        check("rst_cmdr",  32'(cmd_ready),                32'(0));
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);

        // Full write then read-back, with latency measurement
        issue(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, w);
        issue(1'b0, 10'h005, 32'h0, 4'h0, w);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && !rsp_valid; i++) cycle();
        check("rd_latency", 32'(cyc - last_rd_cyc), 32'(LAT + 2));
        drain();
        check("rd_full_word", last_pop_data, 32'hDEADBEEF);

        // Partial write over existing word
        issue(1'b1, 10'h005, 32'h0000CAFE, 4'h3, w);
        issue(1'b0, 10'h005, 32'h0, 4'h0, w);
        drain();
        check("rd_partial", last_pop_data, 32'hDEADCAFE);

        // Preload addr = value, then back-to-back reads at full rate
        for (int i = 0; i < 16; i++) issue(1'b1, 10'(i), 32'(i), 4'hF, w);
        rsp_ready = 1'b1;
        stalls = 0;
        pop_first = -1;
        p0 = n_pops;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 10'(i), 32'h0, 4'h0, w);
            stalls += w;
        end
        drain();
        check("b2b_stalls", 32'(stalls), 32'(0));
        check("b2b_count", 32'(n_pops - p0), 32'(8));
        check("b2b_consecutive", 32'(pop_last - pop_first), 32'(7));

        // Back-pressure: responses held off, credits run out after 4 reads
        rsp_ready = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 4; i++) issue(1'b0, 10'(8 + i), 32'h0, 4'h0, w);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_address = 10'd12;
        repeat (3) cycle();
        check("stall_ready", 32'(cmd_ready), 32'(0));
        rsp_ready = 1'b1;
        issue(1'b0, 10'd12, 32'h0, 4'h0, w);
        issue(1'b0, 10'd13, 32'h0, 4'h0, w);
        drain();
        check("stall_count", 32'(n_pops - p0), 32'(6));

        // Interleaved read / write / read: writes produce no response
        p0 = n_pops;
        issue(1'b0, 10'd2, 32'h0, 4'h0, w);
        issue(1'b1, 10'd9, 32'h12345678, 4'hF, w);
        issue(1'b0, 10'd3, 32'h0, 4'h0, w);
        drain();
        check("ilv_count", 32'(n_pops - p0), 32'(2));

        // Reset with reads in flight
        rsp_ready = 1'b0;
        issue(1'b0, 10'd1, 32'h0, 4'h0, w);
        issue(1'b0, 10'd2, 32'h0, 4'h0, w);
        cycle();
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("inrst_cs",   32'(onchip_memory_chipselect), 32'(0));
        check("inrst_rspv", 32'(rsp_valid),                32'(0));
        check("inrst_cmdr", 32'(cmd_ready),                32'(0));
        model_reset();
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        @(negedge clk_clk);
        check("post_rst_ready", 32'(cmd_ready), 32'(1));
        p0 = n_pops;
        rsp_ready = 1'b1;
        repeat (8) cycle();
        check("post_rst_no_rsp", 32'(n_pops - p0), 32'(0));

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            cmd_valid   = ($urandom_range(0, 9) < 7);
            cmd_write   = ($urandom_range(0, 9) < 4);
            cmd_address = 10'($urandom_range(0, 15));
            cmd_data    = $urandom;
            cmd_mask    = 4'($urandom_range(0, 15));
            rsp_ready   = ($urandom_range(0, 9) < 6);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
